mips_noc_interface: RTL
=======================

Name: mips_noc_interface

Overview:
- Network interface (NI) between one pipelined MIPS core and its NoC router port; sits directly downstream of the core's execute stage.
- TX: accepts send requests (data, destination) from the core and packetizes each into a head flit plus a body flit on a valid/ready link to the router.
- RX: depacketizes router flits, buffers the words, and delivers them to the core's register-write path on request.

Parameters:
- DATA_W, 32, payload word width.
- NODE_W, 2, node address width.
- TX_DEPTH, 4, TX FIFO entries (power of 2).
- RX_DEPTH, 4, RX FIFO entries (power of 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- current_node  in  NODE_W  this node's address.
- to_ni  in  DATA_W  word to send.
- dest_add_E  in  NODE_W  destination node of the word.
- proc_valid_E  in  1  send request, one word per cycle high.
- proc_ready_in_E  in  1  core requests one received word this cycle.
- wd_NI  out  DATA_W  received word to the core.
- data_valid  out  1  one-cycle pulse: wd_NI holds a newly delivered word.
- mips_ni  out  1  RX FIFO non-empty.
- rx_src  out  NODE_W  source node of the word on wd_NI.
- tx_full  out  1  TX FIFO full.
- tx_overflow  out  1  sticky: a send was dropped because TX was full.
- rx_proto_err  out  1  sticky: illegal flit sequence received.
- flit_out  out  DATA_W+2  flit to router, {type[1:0], payload}.
- flit_out_valid  out  1  flit_out valid.
- flit_out_ready  in  1  router accepts flit_out.
- flit_in  in  DATA_W+2  flit from router.
- flit_in_valid  in  1  flit_in valid.
- flit_in_ready  out  1  NI accepts flit_in.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: FIFOs empty; both FSMs idle; all outputs 0.
- Flit types:
  - 2'b01 head: payload = {dest, src, zeros}, dest in the MSBs.
  - 2'b10 body: payload = data.
  - 2'b00 and 2'b11 are illegal.
- A transfer occurs on any cycle with valid && ready.

TX push:
- proc_valid_E && !tx_full pushes {dest_add_E, to_ni}.
- proc_valid_E && tx_full drops the word and sets tx_overflow.
- dest == current_node is sent normally; the router loops it back.

TX FSM (T_IDLE, T_HEAD, T_BODY):
- T_IDLE: flit_out_valid=0; FIFO non-empty -> T_HEAD next cycle.
- T_HEAD: drive head flit from FIFO head entry; src = current_node. On transfer -> T_BODY.
- T_BODY: drive body flit. On transfer, pop FIFO, then:
  - -> T_HEAD if entries remain, counting a same-cycle push;
  - else -> T_IDLE.
- flit_out and flit_out_valid stay stable while valid && !ready.
- Push and pop in the same cycle are both honoured; the count is unchanged.

RX FSM (R_HEAD, R_BODY):
- R_HEAD:
  - flit_in_ready=1.
  - Head transfer: capture src -> R_BODY.
  - Any other flit: consumed, dropped, sets rx_proto_err.
- R_BODY:
  - flit_in_ready = !rx_full.
  - Body transfer: push {src, data}, return to R_HEAD.
  - Head transfer: overwrite src, stay in R_BODY, set rx_proto_err.
  - Illegal type: consumed, dropped, sets rx_proto_err.

Core delivery:
- proc_ready_in_E && mips_ni: pop RX FIFO; next cycle wd_NI=data, rx_src=src, data_valid=1.
- proc_ready_in_E && !mips_ni: no pop, data_valid=0, wd_NI/rx_src hold.
- data_valid is high for exactly one cycle per pop.
- Latency from flit_in body transfer to mips_ni=1 is 1 cycle.
- Simultaneous RX push and pop are both honoured.

Other rules:
- Pointers wrap modulo depth.
- Counts are log2(depth)+1 bits.
- rst mid-packet aborts both FSMs and discards partial packets and all FIFO contents.
- Sticky flags clear only on rst.

Test Plan:
1. Single send: node=1, dest=3, to_ni=32'hDEADBEEF, flit_out_ready=1 -> flit_out = {01,3,1,0...} then {10,DEADBEEF} on consecutive cycles; T_IDLE after.
2. Back-pressure/overflow: flit_out_ready=0, 5 consecutive sends -> tx_full after 4th, tx_overflow=1, 4 packets emerge in order once ready=1; flit stable while stalled.
3. Receive: head src=2, body 32'h12345678 -> mips_ni=1; pulse proc_ready_in_E -> next cycle wd_NI=12345678, rx_src=2, data_valid one cycle, mips_ni=0.
4. RX full: 4 packets with no reads -> flit_in_ready=0 in R_BODY on 5th body; read one -> 5th body accepted; data order preserved.
5. Protocol error: body flit in R_HEAD, then head,head,body -> first body dropped, rx_proto_err=1, delivered word tagged with second head's src.
6. Reset mid-packet: rst during T_BODY stall -> next cycle flit_out_valid=0, tx_full=0, flags 0, mips_ni=0.

Source files
------------

// File: rtl/mips_noc_interface.sv
// ---------------------------------------------------------------------------
// mips_noc_interface
//
// Network interface between one pipelined MIPS core (execute stage) and its
// NoC router port.
//
//   TX: words sent by the core are queued with their destination, then
//       emitted as a head flit {01, dest, src, 0...} followed by a body flit
//       {10, data} on a valid/ready link to the router.
//   RX: router flits are depacketized; each completed head+body pair is
//       queued as {src, data} and handed to the core's write-back path when
//       the core asks for it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   current_node             address of this node (src field of head flits)
//   to_ni, dest_add_E,
//   proc_valid_E             core send request (one word per cycle)
//   tx_full, tx_overflow     TX queue full / sticky dropped-send flag
//   flit_out*, flit_in*      router link, valid/ready handshakes
//   proc_ready_in_E          core requests one received word
//   wd_NI, rx_src,
//   data_valid               delivered word, its source, one-cycle strobe
//   mips_ni                  RX queue holds at least one word
//   rx_proto_err             sticky: illegal flit sequence seen on flit_in
// ---------------------------------------------------------------------------
module mips_noc_interface #(
    parameter int DATA_W   = 32,
    parameter int NODE_W   = 2,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] current_node,
    input  logic [DATA_W-1:0] to_ni,
    input  logic [NODE_W-1:0] dest_add_E,
    input  logic              proc_valid_E,
    input  logic              proc_ready_in_E,
    output logic [DATA_W-1:0] wd_NI,
    output logic              data_valid,
    output logic              mips_ni,
    output logic [NODE_W-1:0] rx_src,
    output logic              tx_full,
    output logic              tx_overflow,
    output logic              rx_proto_err,
    output logic [DATA_W+1:0] flit_out,
    output logic              flit_out_valid,
    input  logic              flit_out_ready,
    input  logic [DATA_W+1:0] flit_in,
    input  logic              flit_in_valid,
    output logic              flit_in_ready
);

    localparam int TXA   = $clog2(TX_DEPTH);
    localparam int RXA   = $clog2(RX_DEPTH);
    localparam int ENT_W = NODE_W + DATA_W;
    localparam int PAD_W = DATA_W - 2 * NODE_W;

    localparam logic [TXA:0]   TX_FULL_CNT = (TXA + 1)'(TX_DEPTH);
    localparam logic [TXA:0]   TX_CNT_ONE  = (TXA + 1)'(1);
    localparam logic [TXA-1:0] TX_PTR_ONE  = TXA'(1);
    localparam logic [RXA:0]   RX_FULL_CNT = (RXA + 1)'(RX_DEPTH);
    localparam logic [RXA:0]   RX_CNT_ONE  = (RXA + 1)'(1);
    localparam logic [RXA-1:0] RX_PTR_ONE  = RXA'(1);

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b10;

    typedef enum logic [1:0] {T_IDLE, T_HEAD, T_BODY} tx_state_t;
    typedef enum logic       {R_HEAD, R_BODY}         rx_state_t;

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] r_tx_mem [TX_DEPTH];
    logic [TXA-1:0]   r_tx_wr_ptr;
    logic [TXA-1:0]   r_tx_rd_ptr;
    logic [TXA:0]     r_tx_count;
    logic             r_tx_overflow;
    tx_state_t        r_tx_state;
    tx_state_t        w_tx_next;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic [ENT_W-1:0] w_tx_entry;

    assign tx_full     = (r_tx_count == TX_FULL_CNT);
    assign tx_overflow = r_tx_overflow;
    assign w_tx_push   = proc_valid_E && !tx_full;
    assign w_tx_entry  = r_tx_mem[r_tx_rd_ptr];

    // Storage needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= {dest_add_E, to_ni};
        end
    end

    // The entry is popped only once its body flit has left, so the head
    // entry stays put (and flit_out stays stable) through any stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wr_ptr   <= '0;
            r_tx_rd_ptr   <= '0;
            r_tx_count    <= '0;
            r_tx_overflow <= 1'b0;
            r_tx_state    <= T_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + TX_PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + TX_PTR_ONE;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + TX_CNT_ONE;
                2'b01:   r_tx_count <= r_tx_count - TX_CNT_ONE;
                default: r_tx_count <= r_tx_count;
            endcase
            if (proc_valid_E && tx_full) begin
                r_tx_overflow <= 1'b1;
            end
        end
    end

    // After a body flit, go straight back to T_HEAD if anything is left,
    // including a word being pushed in the same cycle.
    always_comb begin
        w_tx_next      = r_tx_state;
        flit_out       = '0;
        flit_out_valid = 1'b0;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                if (r_tx_count != '0) begin
                    w_tx_next = T_HEAD;
                end
            end
            T_HEAD: begin
                flit_out_valid = 1'b1;
                flit_out       = {FT_HEAD, w_tx_entry[ENT_W-1 -: NODE_W],
                                  current_node, {PAD_W{1'b0}}};
                if (flit_out_ready) begin
                    w_tx_next = T_BODY;
                end
            end
            T_BODY: begin
                flit_out_valid = 1'b1;
                flit_out       = {FT_BODY, w_tx_entry[DATA_W-1:0]};
                if (flit_out_ready) begin
                    w_tx_pop = 1'b1;
                    if ((r_tx_count > TX_CNT_ONE) || w_tx_push) begin
                        w_tx_next = T_HEAD;
                    end else begin
                        w_tx_next = T_IDLE;
                    end
                end
            end
            default: w_tx_next = T_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  r_rx_mem [RX_DEPTH];
    logic [RXA-1:0]    r_rx_wr_ptr;
    logic [RXA-1:0]    r_rx_rd_ptr;
    logic [RXA:0]      r_rx_count;
    logic [NODE_W-1:0] r_rx_cur_src;
    logic              r_rx_proto_err;
    logic [DATA_W-1:0] r_wd;
    logic [NODE_W-1:0] r_rx_src;
    logic              r_data_valid;
    rx_state_t         r_rx_state;
    rx_state_t         w_rx_next;
    logic [1:0]        w_flit_type;
    logic [NODE_W-1:0] w_flit_src;
    logic              w_rx_full;
    logic              w_rx_xfer;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_src_load;
    logic              w_rx_err;

    assign w_flit_type  = flit_in[DATA_W+1 -: 2];
    assign w_flit_src   = flit_in[DATA_W-NODE_W-1 -: NODE_W];
    assign w_rx_full    = (r_rx_count == RX_FULL_CNT);
    assign mips_ni      = (r_rx_count != '0);
    assign w_rx_pop     = proc_ready_in_E && mips_ni;
    assign rx_proto_err = r_rx_proto_err;
    assign wd_NI        = r_wd;
    assign rx_src       = r_rx_src;
    assign data_valid   = r_data_valid;

    // While waiting for a head every flit is consumed, so stray flits can
    // never wedge the link; only a body needs room in the queue.
    assign flit_in_ready = (r_rx_state == R_HEAD) || !w_rx_full;
    assign w_rx_xfer     = flit_in_valid && flit_in_ready;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= {r_rx_cur_src, flit_in[DATA_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wr_ptr    <= '0;
            r_rx_rd_ptr    <= '0;
            r_rx_count     <= '0;
            r_rx_cur_src   <= '0;
            r_rx_proto_err <= 1'b0;
            r_rx_state     <= R_HEAD;
        end else begin
            r_rx_state <= w_rx_next;
            if (w_src_load) begin
                r_rx_cur_src <= w_flit_src;
            end
            if (w_rx_err) begin
                r_rx_proto_err <= 1'b1;
            end
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + RX_PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + RX_PTR_ONE;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + RX_CNT_ONE;
                2'b01:   r_rx_count <= r_rx_count - RX_CNT_ONE;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // A second head while waiting for a body restarts the packet with the
    // newer source; the orphaned head is reported as a protocol error.
    always_comb begin
        w_rx_next  = r_rx_state;
        w_rx_push  = 1'b0;
        w_src_load = 1'b0;
        w_rx_err   = 1'b0;
        case (r_rx_state)
            R_HEAD: begin
                if (w_rx_xfer) begin
                    if (w_flit_type == FT_HEAD) begin
                        w_src_load = 1'b1;
                        w_rx_next  = R_BODY;
                    end else begin
                        w_rx_err = 1'b1;
                    end
                end
            end
            R_BODY: begin
                if (w_rx_xfer) begin
                    if (w_flit_type == FT_BODY) begin
                        w_rx_push = 1'b1;
                        w_rx_next = R_HEAD;
                    end else if (w_flit_type == FT_HEAD) begin
                        w_src_load = 1'b1;
                        w_rx_err   = 1'b1;
                    end else begin
                        w_rx_err = 1'b1;
                    end
                end
            end
            default: w_rx_next = R_HEAD;
        endcase
    end

    // Delivery register: wd_NI/rx_src hold their last word until the next
    // successful pop; data_valid marks the one cycle a new word appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd         <= '0;
            r_rx_src     <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rx_pop;
            if (w_rx_pop) begin
                {r_rx_src, r_wd} <= r_rx_mem[r_rx_rd_ptr];
            end
        end
    end

endmodule
